// File: rtl/rv32i_multicycle_cpu.sv
// Multicycle RV32I core on one shared instruction/data bus (BRAM + GPIO); optional CPU_REGFILE_RESET_EN clears x1..x31 on reset.
// Latency: 3 cycles ALU/jump/branch, 4 cycles store, 5 cycles load; bus read data arrives one cycle after the address.
// Backpressure: none; the bus is assumed always ready, and every access completes in its own FSM state.
module rv32i_multicycle_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] TomemReadData,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  byteMask,
  output logic        memWrite
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, LOADWB} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t      state_q, state_d;
  logic [31:0] PC, pc_d;
  logic [31:0] InstructionRegister, ir_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] RegFile [0:31];

  // Instruction fields; the IR is stable from EXECUTE through LOADWB
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, op_b, alu_res, pc_plus4, ld_addr, st_addr;
  logic        br_taken, is_store;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic        rf_we;
  logic [31:0] rf_wd;

  assign opcode   = InstructionRegister[6:0];
  assign rd       = InstructionRegister[11:7];
  assign funct3   = InstructionRegister[14:12];
  assign rs1      = InstructionRegister[19:15];
  assign rs2      = InstructionRegister[24:20];
  assign alt      = InstructionRegister[30];
  assign imm_i    = {{20{InstructionRegister[31]}}, InstructionRegister[31:20]};
  assign imm_s    = {{20{InstructionRegister[31]}}, InstructionRegister[31:25], InstructionRegister[11:7]};
  assign imm_b    = {{19{InstructionRegister[31]}}, InstructionRegister[31], InstructionRegister[7],
                     InstructionRegister[30:25], InstructionRegister[11:8], 1'b0};
  assign imm_u    = {InstructionRegister[31:12], 12'b0};
  assign imm_j    = {{11{InstructionRegister[31]}}, InstructionRegister[31], InstructionRegister[19:12],
                     InstructionRegister[20], InstructionRegister[30:21], 1'b0};
  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : RegFile[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : RegFile[rs2];
  assign op_b     = (opcode == OPC_OP) ? rs2_val : imm_i;
  assign pc_plus4 = PC + 32'd4;
  assign ld_addr  = rs1_val + imm_i;
  assign st_addr  = rs1_val + imm_s;
  assign is_store = (opcode == OPC_STORE);

  // Bus outputs depend only on state and latched registers, never on read data
  assign memAddress   = (state_q == MEM) ? ea_q : PC;
  assign memWrite     = (state_q == MEM) && is_store && !reset;
  assign byteMask     = ((state_q == MEM) && is_store) ? mask_q : 4'b1111;
  assign memWriteData = wdata_q;

  // ALU for OP / OP-IMM; subtract only exists in the register form
  always_comb begin
    alu_res = 32'd0;
    case (funct3)
      3'b000:  alu_res = ((opcode == OPC_OP) && alt) ? rs1_val - op_b : rs1_val + op_b;
      3'b001:  alu_res = rs1_val << op_b[4:0];
      3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
      3'b011:  alu_res = {31'd0, rs1_val < op_b};
      3'b100:  alu_res = rs1_val ^ op_b;
      3'b101:  alu_res = alt ? 32'($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
      3'b110:  alu_res = rs1_val | op_b;
      default: alu_res = rs1_val & op_b;
    endcase
  end

  // Branch condition; reserved funct3 encodings fall through as not taken
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Load lane selection; halfwords ignore addr[0], words ignore addr[1:0]
  always_comb begin
    ld_byte = TomemReadData[7:0];
    case (ea_q[1:0])
      2'd1:    ld_byte = TomemReadData[15:8];
      2'd2:    ld_byte = TomemReadData[23:16];
      2'd3:    ld_byte = TomemReadData[31:24];
      default: ld_byte = TomemReadData[7:0];
    endcase
    ld_half = ea_q[1] ? TomemReadData[31:16] : TomemReadData[15:0];
    case (funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = TomemReadData;
    endcase
  end

  // Next-state, PC, latch and register-write decisions for every FSM state
  always_comb begin
    state_d = state_q;
    pc_d    = PC;
    ir_d    = InstructionRegister;
    ea_d    = ea_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rf_we   = 1'b0;
    rf_wd   = alu_res;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        ir_d    = TomemReadData;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        state_d = FETCH;
        pc_d    = pc_plus4;
        case (opcode)
          OPC_OP, OPC_OPIMM: rf_we = 1'b1;
          OPC_LUI: begin
            rf_we = 1'b1;
            rf_wd = imm_u;
          end
          OPC_AUIPC: begin
            rf_we = 1'b1;
            rf_wd = PC + imm_u;
          end
          OPC_JAL: begin
            rf_we = 1'b1;
            rf_wd = pc_plus4;
            pc_d  = PC + imm_j;
          end
          OPC_JALR: begin
            rf_we = 1'b1;
            rf_wd = pc_plus4;
            pc_d  = ld_addr & ~32'd1;
          end
          OPC_BRANCH: if (br_taken) pc_d = PC + imm_b;
          OPC_LOAD: begin
            ea_d    = ld_addr;
            pc_d    = PC;
            state_d = MEM;
          end
          OPC_STORE: begin
            ea_d    = st_addr;
            pc_d    = PC;
            state_d = MEM;
            case (funct3[1:0])
              2'b00: begin
                mask_d  = 4'b0001 << st_addr[1:0];
                wdata_d = {4{rs2_val[7:0]}};
              end
              2'b01: begin
                mask_d  = st_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{rs2_val[15:0]}};
              end
              default: begin
                mask_d  = 4'b1111;
                wdata_d = rs2_val;
              end
            endcase
          end
          default: ; // FENCE, SYSTEM and unknown opcodes retire as NOPs
        endcase
      end
      MEM: begin
        if (is_store) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end else begin
          state_d = LOADWB;
        end
      end
      LOADWB: begin
        rf_we   = 1'b1;
        rf_wd   = ld_val;
        pc_d    = pc_plus4;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // FSM and control registers; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= FETCH;
      PC                  <= 32'd0;
      InstructionRegister <= 32'd0;
      ea_q                <= 32'd0;
      wdata_q             <= 32'd0;
      mask_q              <= 4'b1111;
    end else begin
      state_q             <= state_d;
      PC                  <= pc_d;
      InstructionRegister <= ir_d;
      ea_q                <= ea_d;
      wdata_q             <= wdata_d;
      mask_q              <= mask_d;
    end
  end

  // Register file write port; x0 is never written so it stays a read-as-zero slot
  always_ff @(posedge clk) begin
`ifdef CPU_REGFILE_RESET_EN
    if (reset) begin
      for (int i = 1; i < 32; i++) RegFile[i] <= 32'd0;
    end else if (rf_we && (rd != 5'd0)) begin
      RegFile[rd] <= rf_wd;
    end
`else
    if (!reset && rf_we && (rd != 5'd0)) begin
      RegFile[rd] <= rf_wd;
    end
`endif
  end

endmodule

// File: tb/tb_rv32i_multicycle_cpu.sv
// Directed bench for rv32i_multicycle_cpu with a one-cycle-latency bus model.
// Latency: program ROM at 0x00-0x3F, data RAM at 0x100-0x1FF, GPIO store counter at 0xFFFFFFF0.
// Backpressure: none; the model answers every access on the following cycle.
module tb_rv32i_multicycle_cpu;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] TomemReadData;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [3:0]  byteMask;
  logic        memWrite;

  logic [31:0] prog [0:15];
  logic [31:0] ram  [0:63] = '{default: 32'h0};
  int          gpio_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  rv32i_multicycle_cpu dut (
    .clk           (clk),
    .reset         (reset),
    .TomemReadData (TomemReadData),
    .memAddress    (memAddress),
    .memWriteData  (memWriteData),
    .byteMask      (byteMask),
    .memWrite      (memWrite)
  );

  always #5 clk = ~clk;

  // Synchronous bus model: read data registered, byte-lane writes into RAM, GPIO store counter
  always @(posedge clk) begin
    if (memAddress[31:6] == 26'd0)
      TomemReadData <= prog[memAddress[5:2]];
    else if (memAddress[31:8] == 24'h000001)
      TomemReadData <= ram[memAddress[7:2]];
    else
      TomemReadData <= 32'h0;
    if (memWrite === 1'b1) begin
      if (memAddress[31:8] == 24'h000001) begin
        for (int i = 0; i < 4; i++)
          if (byteMask[i]) ram[memAddress[7:2]][8*i +: 8] <= memWriteData[8*i +: 8];
      end
      if (memAddress == 32'hFFFF_FFF0) gpio_cnt <= gpio_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 32'h0000_0013;
  endtask

  // Hold reset across one rising edge, then release just after it
  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    // Program A: basic ALU, branches, jump
    clear_prog();
    prog[0] = 32'h00500093; // addi x1,x0,5
    prog[1] = 32'h00500113; // addi x2,x0,5
    prog[2] = 32'h00900213; // addi x4,x0,9
    prog[3] = 32'h00209463; // bne  x1,x2,+8 (not taken)
    prog[4] = 32'h00208463; // beq  x1,x2,+8 (taken)
    prog[5] = 32'h00100393; // addi x7,x0,1 (skipped)
    prog[6] = 32'hFF1FF2EF; // jal  x5,-16
    @(posedge clk);
    #1;
    check("rst_memwrite", {31'd0, memWrite}, 32'd0);
    pulse_reset();
    check("rst_pc", dut.PC, 32'h0);
    check("rst_ir", dut.InstructionRegister, 32'h0);
    check("first_fetch_addr", memAddress, 32'h0);
    check("fetch_mask", {28'd0, byteMask}, 32'hF);
    step(3);
    check("addi_x1", dut.RegFile[1], 32'd5);
    check("addi_next_fetch", memAddress, 32'h4);
    step(6);
    check("addi_x4", dut.RegFile[4], 32'd9);
    step(3);
    check("bne_not_taken_pc", dut.PC, 32'h10);
    step(3);
    check("beq_taken_pc", dut.PC, 32'h18);
    step(3);
    check("jal_pc", dut.PC, 32'h08);
    check("jal_link", dut.RegFile[5], 32'h1C);
    check("jal_fetch_addr", memAddress, 32'h08);

    // Program B: x0, arithmetic edge cases, JALR bit-0 clearing
    reset = 1'b1;
    clear_prog();
    prog[0] = 32'h00700013; // addi x0,x0,7
    prog[1] = 32'h00100093; // addi x1,x0,1
    prog[2] = 32'h40100133; // sub  x2,x0,x1
    prog[3] = 32'h800001B7; // lui  x3,0x80000
    prog[4] = 32'h4041D213; // srai x4,x3,4
    prog[5] = 32'h000002B3; // add  x5,x0,x0
    prog[6] = 32'h00103333; // sltu x6,x0,x1
    prog[7] = 32'h000123B3; // slt  x7,x2,x0
    prog[8] = 32'h02E08467; // jalr x8,0x2E(x1)
    pulse_reset();
    step(24);
    check("x0_not_written", {31'd0, dut.RegFile[0] === 32'd7}, 32'd0);
    check("add_x0_reads_zero", dut.RegFile[5], 32'h0);
    check("sub_wrap", dut.RegFile[2], 32'hFFFF_FFFF);
    check("lui", dut.RegFile[3], 32'h8000_0000);
    check("srai", dut.RegFile[4], 32'hF800_0000);
    check("sltu", dut.RegFile[6], 32'd1);
    check("slt_signed", dut.RegFile[7], 32'd1);
    step(3);
    check("jalr_pc_bit0", dut.PC, 32'h2E);
    check("jalr_link", dut.RegFile[8], 32'h24);

    // Program C: stores, loads, GPIO store, reset during a store's MEM
    reset = 1'b1;
    clear_prog();
    prog[0]  = 32'h10000113; // addi x2,x0,0x100
    prog[1]  = 32'h08000093; // addi x1,x0,0x80
    prog[2]  = 32'h001100A3; // sb   x1,1(x2)
    prog[3]  = 32'h00110183; // lb   x3,1(x2)
    prog[4]  = 32'h00114203; // lbu  x4,1(x2)
    prog[5]  = 32'h00111123; // sh   x1,2(x2)
    prog[6]  = 32'h00011283; // lh   x5,0(x2)
    prog[7]  = 32'h00012303; // lw   x6,0(x2)
    prog[8]  = 32'hFF000393; // addi x7,x0,-16
    prog[9]  = 32'h0003A023; // sw   x0,0(x7)
    prog[10] = 32'h00112023; // sw   x1,0(x2)
    pulse_reset();
    step(9);
    check("sb_memwrite", {31'd0, memWrite}, 32'd1);
    check("sb_mask", {28'd0, byteMask}, 32'b0010);
    check("sb_data", memWriteData, 32'h8080_8080);
    check("sb_addr", memAddress, 32'h101);
    step(1);
    check("sb_strobe_one_cycle", {31'd0, memWrite}, 32'd0);
    check("sb_pc", dut.PC, 32'h0C);
    step(5);
    check("lb_sign", dut.RegFile[3], 32'hFFFF_FF80);
    step(5);
    check("lbu_zero", dut.RegFile[4], 32'h0000_0080);
    step(3);
    check("sh_mask", {28'd0, byteMask}, 32'b1100);
    check("sh_data", memWriteData, 32'h0080_0080);
    check("sh_addr", memAddress, 32'h102);
    step(6);
    check("lh_sign", dut.RegFile[5], 32'hFFFF_8000);
    step(5);
    check("lw_word", dut.RegFile[6], 32'h0080_8000);
    step(6);
    check("gpio_memwrite", {31'd0, memWrite}, 32'd1);
    check("gpio_addr", memAddress, 32'hFFFF_FFF0);
    check("gpio_mask", {28'd0, byteMask}, 32'hF);
    step(1);
    check("gpio_pulses", gpio_cnt, 32'd1);
    check("gpio_next_pc", dut.PC, 32'h28);
    step(3);
    reset = 1'b1;
    #1;
    check("abort_memwrite", {31'd0, memWrite}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_pc", dut.PC, 32'h0);
    check("abort_fetch_addr", memAddress, 32'h0);
    check("abort_ram_kept", ram[0], 32'h0080_8000);
    check("abort_gpio_pulses", gpio_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
